edge_detector_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-bit rising-edge detector.
- Each channel synchronises an asynchronous input and detects rise, fall or both edges, selected per channel at run time.
- Each channel applies a programmable hold-off window between pulses and keeps a sticky flag plus a saturating event counter for software polling.
- Sits between external pins or status lines and the interrupt/status logic.

---
 rtl/edge_detector_mc_if.sv | 24 ++
 rtl/edge_detector_mc.sv | 110 +++++++++++
 tb/tb_edge_detector_mc.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detector_mc_if.sv
// Channel-side bus of the multi-channel edge detector: raw inputs, per-channel
// mode and clear going in, pulse/status/counter vectors coming back.
interface edge_detector_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       signal_in;
  logic [2*NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       edge_out;
  logic [NUM_CH-1:0]       edge_type;
  logic [NUM_CH-1:0]       evt_sticky;
  logic [NUM_CH*CNT_W-1:0] evt_cnt;

  modport master (
    output signal_in, mode, clr,
    input  edge_out, edge_type, evt_sticky, evt_cnt
  );

  modport slave (
    input  signal_in, mode, clr,
    output edge_out, edge_type, evt_sticky, evt_cnt
  );
endinterface

// File: rtl/edge_detector_mc.sv
// Multi-channel synchronising edge detector with per-channel mode, hold-off
// window, sticky flag and saturating event counter.
module edge_detector_mc #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 3,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  edge_detector_mc_if.slave bus
);

  // The hold-off counter must hold both the startup mask and the hold-off value.
  localparam int HC_MAX = (HOLDOFF > SYNC_STAGES + 1) ? HOLDOFF : SYNC_STAGES + 1;
  localparam int HC_W   = (HC_MAX < 2) ? 1 : $clog2(HC_MAX + 1);

  localparam logic [HC_W-1:0]  HC_RESET = HC_W'(SYNC_STAGES + 1);
  localparam logic [HC_W-1:0]  HC_HOLD  = HC_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_CH-1:0]       edge_q;
  logic [NUM_CH-1:0]       type_q;
  logic [NUM_CH-1:0]       sticky_q;
  logic [NUM_CH*CNT_W-1:0] cnt_q;

  assign bus.edge_out   = edge_q;
  assign bus.edge_type  = type_q;
  assign bus.evt_sticky = sticky_q;
  assign bus.evt_cnt    = cnt_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   signal_d;
    logic [HC_W-1:0]        hc;
    logic                   pulse;
    logic                   polarity;
    logic                   sticky;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             ch_mode;
    logic                   sync_last;
    logic                   rise;
    logic                   fall;
    logic                   qual;
    logic                   accept;

    always_comb begin
      ch_mode   = bus.mode[2*i +: 2];
      sync_last = sync[SYNC_STAGES-1];
      rise      = sync_last & ~signal_d;
      fall      = ~sync_last & signal_d;
      qual      = (rise & ch_mode[0]) | (fall & ch_mode[1]);
      accept    = qual & (hc == '0);
    end

    // signal_d follows the synchroniser even while an edge is being suppressed,
    // so a level still held at the end of hold-off never fires a late pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync     <= '0;
        signal_d <= 1'b0;
      end else begin
        sync     <= {sync[SYNC_STAGES-2:0], bus.signal_in[i]};
        signal_d <= sync_last;
      end
    end

    // Reset loads the startup mask so an input already high at release is ignored.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hc       <= HC_RESET;
        pulse    <= 1'b0;
        polarity <= 1'b0;
      end else begin
        pulse <= accept;
        if (accept) begin
          hc       <= HC_HOLD;
          polarity <= rise;
        end else if (hc != '0) begin
          hc <= hc - 1'b1;
        end
      end
    end

    // An accepted edge wins over a same-cycle clear, leaving one counted event.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sticky <= 1'b0;
        cnt    <= '0;
      end else if (accept) begin
        sticky <= 1'b1;
        if (bus.clr[i]) begin
          cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else if (bus.clr[i]) begin
        sticky <= 1'b0;
        cnt    <= '0;
      end
    end

    assign edge_q[i]               = pulse;
    assign type_q[i]               = polarity;
    assign sticky_q[i]             = sticky;
    assign cnt_q[i*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_edge_detector_mc.sv
// Directed self-checking bench for edge_detector_mc: latency, modes, hold-off,
// startup mask, counter saturation/clear and reset during a pulse.
module tb_edge_detector_mc;
  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLDOFF     = 3;
  localparam int CNT_W       = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  edge_detector_mc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  edge_detector_mc #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic [NUM_CH-1:0] sig);
    rst           = 1'b1;
    bus.signal_in = sig;
    bus.clr       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits up to max_cyc negedges for a pulse on channel ch.
  task automatic wait_pulse(input int ch, input int max_cyc, output bit found, output int waited);
    found  = 1'b0;
    waited = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (bus.edge_out[ch]) begin
        found  = 1'b1;
        waited = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.signal_in = '0;
    bus.mode      = '0;
    bus.clr       = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.edge_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_edge_out: got %h expected 0", bus.edge_out); end
    checks++;
    if (bus.edge_type !== 4'h0) begin errors++; $display("[TB] FAIL reset_edge_type: got %h expected 0", bus.edge_type); end
    checks++;
    if (bus.evt_sticky !== 4'h0) begin errors++; $display("[TB] FAIL reset_sticky: got %h expected 0", bus.evt_sticky); end
    checks++;
    if (bus.evt_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", bus.evt_cnt); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.edge_out !== 4'h0) begin errors++; $display("[TB] FAIL idle_edge_out: got %h expected 0", bus.edge_out); end
  endtask

  task automatic test_rise_latency();
    bit found;
    int waited;
    bus.mode         = 8'b00_00_00_01;
    bus.signal_in[0] = 1'b1;
    wait_pulse(0, 8, found, waited);
    checks++;
    if (!found || waited != SYNC_STAGES + 1) begin
      errors++; $display("[TB] FAIL rise_latency: got found=%0d after %0d expected %0d", found, waited, SYNC_STAGES + 1);
    end
    checks++;
    if (bus.edge_type[0] !== 1'b1) begin errors++; $display("[TB] FAIL rise_type: got %b expected 1", bus.edge_type[0]); end
    @(negedge clk);
    checks++;
    if (bus.edge_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL rise_width: got %b expected 0", bus.edge_out[0]); end
    checks++;
    if (bus.evt_cnt[7:0] !== 8'd1) begin errors++; $display("[TB] FAIL rise_cnt: got %0d expected 1", bus.evt_cnt[7:0]); end
    checks++;
    if (bus.evt_sticky[0] !== 1'b1) begin errors++; $display("[TB] FAIL rise_sticky: got %b expected 1", bus.evt_sticky[0]); end
    // A fall is ignored in rise-only mode.
    bus.signal_in[0] = 1'b0;
    wait_pulse(0, 8, found, waited);
    checks++;
    if (found) begin errors++; $display("[TB] FAIL rise_mode_fall: got pulse expected none"); end
    checks++;
    if (bus.evt_cnt[7:0] !== 8'd1) begin errors++; $display("[TB] FAIL rise_cnt_hold: got %0d expected 1", bus.evt_cnt[7:0]); end
  endtask

  task automatic test_both_and_fall();
    bit found;
    int waited;
    bus.mode         = 8'b00_00_11_00;
    bus.signal_in[1] = 1'b1;
    wait_pulse(1, 8, found, waited);
    checks++;
    if (!found || waited != 3) begin errors++; $display("[TB] FAIL both_rise: got found=%0d after %0d expected 3", found, waited); end
    checks++;
    if (bus.edge_type[1] !== 1'b1) begin errors++; $display("[TB] FAIL both_rise_type: got %b expected 1", bus.edge_type[1]); end
    repeat (8 - waited) @(negedge clk);
    bus.signal_in[1] = 1'b0;
    wait_pulse(1, 8, found, waited);
    checks++;
    if (!found || waited != 3) begin errors++; $display("[TB] FAIL both_fall: got found=%0d after %0d expected 3", found, waited); end
    checks++;
    if (bus.edge_type[1] !== 1'b0) begin errors++; $display("[TB] FAIL both_fall_type: got %b expected 0", bus.edge_type[1]); end
    checks++;
    if (bus.evt_cnt[15:8] !== 8'd2) begin errors++; $display("[TB] FAIL both_cnt: got %0d expected 2", bus.evt_cnt[15:8]); end
    repeat (6) @(negedge clk);
    bus.mode         = 8'b00_00_10_00;
    bus.signal_in[1] = 1'b1;
    wait_pulse(1, 8, found, waited);
    checks++;
    if (found) begin errors++; $display("[TB] FAIL fall_mode_rise: got pulse expected none"); end
    bus.signal_in[1] = 1'b0;
    wait_pulse(1, 8, found, waited);
    checks++;
    if (!found || waited != 3) begin errors++; $display("[TB] FAIL fall_mode_fall: got found=%0d after %0d expected 3", found, waited); end
    checks++;
    if (bus.edge_type[1] !== 1'b0) begin errors++; $display("[TB] FAIL fall_mode_type: got %b expected 0", bus.edge_type[1]); end
    checks++;
    if (bus.evt_cnt[15:8] !== 8'd3) begin errors++; $display("[TB] FAIL fall_mode_cnt: got %0d expected 3", bus.evt_cnt[15:8]); end
    bus.clr[1] = 1'b1;
    @(negedge clk);
    bus.clr[1] = 1'b0;
    checks++;
    if (bus.evt_cnt[15:8] !== 8'd0 || bus.evt_sticky[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_ch1: got cnt=%0d sticky=%b expected 0/0", bus.evt_cnt[15:8], bus.evt_sticky[1]);
    end
  endtask

  task automatic test_holdoff();
    int pulses   = 0;
    int last     = -1;
    int min_gap  = 1000;
    int back2back = 0;
    bus.mode = 8'b00_11_00_00;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (bus.edge_out[2]) begin
        pulses++;
        if (last >= 0 && i - last < min_gap) min_gap = i - last;
        if (last == i - 1) back2back++;
        last = i;
      end
      if (i < 12 && i % 2 == 0) bus.signal_in[2] = ~bus.signal_in[2];
    end
    checks++;
    if (pulses != 3) begin errors++; $display("[TB] FAIL holdoff_pulses: got %0d expected 3", pulses); end
    checks++;
    if (min_gap != HOLDOFF + 1) begin errors++; $display("[TB] FAIL holdoff_gap: got %0d expected %0d", min_gap, HOLDOFF + 1); end
    checks++;
    if (back2back != 0) begin errors++; $display("[TB] FAIL holdoff_b2b: got %0d expected 0", back2back); end
    checks++;
    if (bus.evt_cnt[23:16] !== 8'd3) begin errors++; $display("[TB] FAIL holdoff_cnt: got %0d expected 3", bus.evt_cnt[23:16]); end
    checks++;
    if (bus.edge_type[2] !== 1'b1) begin errors++; $display("[TB] FAIL holdoff_type: got %b expected 1", bus.edge_type[2]); end
  endtask

  task automatic test_startup_mask();
    int seen = 0;
    bus.mode = 8'hFF;
    rst           = 1'b1;
    bus.signal_in = 4'hF;
    bus.clr       = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.edge_out !== 4'h0 || bus.evt_cnt !== 32'h0) begin
      errors++; $display("[TB] FAIL mask_in_reset: got edge=%h cnt=%h expected 0/0", bus.edge_out, bus.evt_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.edge_out != 4'h0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL mask_pulses: got %0d expected 0", seen); end
    checks++;
    if (bus.evt_cnt !== 32'h0 || bus.evt_sticky !== 4'h0) begin
      errors++; $display("[TB] FAIL mask_status: got cnt=%h sticky=%h expected 0/0", bus.evt_cnt, bus.evt_sticky);
    end
  endtask

  task automatic test_saturation_clr();
    int pulses = 0;
    do_reset(4'h0);
    bus.mode = 8'b11_00_00_00;
    repeat (4) @(negedge clk);
    for (int e = 0; e < 256; e++) begin
      bus.signal_in[3] = ~bus.signal_in[3];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.edge_out[3]) pulses++;
      end
      if (e == 254) begin
        checks++;
        if (bus.evt_cnt[31:24] !== 8'd255) begin errors++; $display("[TB] FAIL sat_reach: got %0d expected 255", bus.evt_cnt[31:24]); end
      end
    end
    checks++;
    if (pulses != 256) begin errors++; $display("[TB] FAIL sat_pulses: got %0d expected 256", pulses); end
    checks++;
    if (bus.evt_cnt[31:24] !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", bus.evt_cnt[31:24]); end
    // Clear lands on the same posedge as the next accepted edge.
    bus.signal_in[3] = ~bus.signal_in[3];
    repeat (2) @(negedge clk);
    bus.clr[3] = 1'b1;
    @(negedge clk);
    bus.clr[3] = 1'b0;
    checks++;
    if (bus.edge_out[3] !== 1'b1) begin errors++; $display("[TB] FAIL clr_edge_pulse: got %b expected 1", bus.edge_out[3]); end
    checks++;
    if (bus.evt_cnt[31:24] !== 8'd1 || bus.evt_sticky[3] !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_set_wins: got cnt=%0d sticky=%b expected 1/1", bus.evt_cnt[31:24], bus.evt_sticky[3]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit found;
    int waited;
    int seen = 0;
    do_reset(4'h0);
    bus.mode = 8'b00_00_00_01;
    repeat (4) @(negedge clk);
    bus.signal_in[0] = 1'b1;
    wait_pulse(0, 8, found, waited);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL midrst_pre_pulse: got none expected pulse"); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.edge_out !== 4'h0 || bus.edge_type !== 4'h0 || bus.evt_sticky !== 4'h0 || bus.evt_cnt !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_clear: got edge=%h type=%h sticky=%h cnt=%h expected all 0",
                         bus.edge_out, bus.edge_type, bus.evt_sticky, bus.evt_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.edge_out[0]) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL midrst_mask: got %0d pulses expected 0", seen); end
    bus.signal_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus.signal_in[0] = 1'b1;
    wait_pulse(0, 8, found, waited);
    checks++;
    if (!found || waited != SYNC_STAGES + 1) begin
      errors++; $display("[TB] FAIL midrst_after: got found=%0d after %0d expected %0d", found, waited, SYNC_STAGES + 1);
    end
    checks++;
    if (bus.evt_cnt[7:0] !== 8'd1) begin errors++; $display("[TB] FAIL midrst_cnt: got %0d expected 1", bus.evt_cnt[7:0]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rise_latency();
    test_both_and_fall();
    test_holdoff();
    test_startup_mask();
    test_saturation_clr();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end
endmodule
